// File: rtl/instr_sequencer.sv
// Buffered instruction source: program words are appended while loading, then issued
// in order over a valid/ready handshake until a HALT word, end of program, or forever in loop mode.
module instr_sequencer #(
  parameter int          IW     = 8,
  parameter int          DEPTH  = 16,
  parameter int          AW     = 4,
  parameter logic [3:0]  HALT_W = 4'b0111
) (
  input  logic          clock_pulse,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_data,
  input  logic          start,
  input  logic          loop_en,
  input  logic          instr_ready,
  output logic          instr_valid,
  output logic [IW-1:0] instr_out,
  output logic [AW-1:0] pc,
  output logic [AW:0]   prog_len,
  output logic [1:0]    state,
  output logic          wr_overflow
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

  logic [IW-1:0] mem [DEPTH];

  state_t        state_q;
  logic          valid_q;
  logic [IW-1:0] instr_q;
  logic [AW-1:0] pc_q;
  logic [AW:0]   len_q;
  logic          ovf_q;

  logic [AW:0]   next_idx;
  logic          at_end;
  logic [IW-1:0] next_word;
  logic [IW-1:0] first_word;
  logic          next_is_halt;
  logic          first_is_halt;
  logic          load_idle;
  logic          wr_accept;

  // Only the {mode,opcode} nibble identifies a HALT word; register fields are don't-care.
  assign next_idx      = {1'b0, pc_q} + (AW+1)'(1);
  assign at_end        = (next_idx == len_q);
  assign next_word     = mem[next_idx[AW-1:0]];
  assign first_word    = mem[0];
  assign next_is_halt  = (next_word[IW-1:IW-4] == HALT_W);
  assign first_is_halt = (first_word[IW-1:IW-4] == HALT_W);

  assign load_idle = !reset && !clear && !start && (state_q == ST_LOAD);
  assign wr_accept = load_idle && wr_en && (len_q != FULL_LEN);

  // Program storage is never cleared; prog_len alone decides which words are reachable.
  always_ff @(posedge clock_pulse) begin
    if (wr_accept) begin
      mem[len_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clock_pulse) begin
    if (reset || clear) begin
      state_q <= ST_LOAD;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state_q)
        ST_LOAD, ST_HALT: begin
          if (start) begin
            pc_q <= '0;
            if (len_q == '0 || first_is_halt) begin
              state_q <= ST_HALT;
              valid_q <= 1'b0;
            end else begin
              state_q <= ST_RUN;
              valid_q <= 1'b1;
              instr_q <= first_word;
            end
          end else if (state_q == ST_LOAD && wr_en) begin
            if (len_q != FULL_LEN) begin
              len_q <= len_q + (AW+1)'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (valid_q && instr_ready) begin
            if (at_end) begin
              if (loop_en) begin
                pc_q    <= '0;
                instr_q <= first_word;
              end else begin
                state_q <= ST_HALT;
                valid_q <= 1'b0;
              end
            end else if (next_is_halt) begin
              state_q <= ST_HALT;
              valid_q <= 1'b0;
              pc_q    <= next_idx[AW-1:0];
            end else begin
              pc_q    <= next_idx[AW-1:0];
              instr_q <= next_word;
            end
          end
        end
        default: begin
          state_q <= ST_LOAD;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc          = pc_q;
  assign prog_len    = len_q;
  assign state       = state_q;
  assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a queue-based program model is compared against the
// DUT every cycle, and each scenario's issued-word stream is pinned to hand-computed lists.
module tb_instr_sequencer;

  logic       clock_pulse = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       loop_en = 1'b0;
  logic       instr_ready = 1'b0;
  logic       instr_valid;
  logic [7:0] instr_out;
  logic [3:0] pc;
  logic [4:0] prog_len;
  logic [1:0] state;
  logic       wr_overflow;

  int checks = 0;
  int failures = 0;
  int ovf_pulses = 0;
  bit cmp_en = 1'b0;

  instr_sequencer dut (
    .clock_pulse(clock_pulse), .reset(reset), .clear(clear), .wr_en(wr_en),
    .wr_data(wr_data), .start(start), .loop_en(loop_en), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc(pc), .prog_len(prog_len),
    .state(state), .wr_overflow(wr_overflow)
  );

  always #5 clock_pulse = ~clock_pulse;

  // ---------------- behavioural model ----------------
  localparam int LOAD = 0, RUN = 1, HALT = 2;
  logic [7:0] prog[$];
  int  m_state = LOAD;
  int  m_pc = 0;
  bit  m_valid = 0;
  bit  m_ovf = 0;
  bit  m_pc_known = 1;

  function automatic bit is_halt(logic [7:0] w);
    return w[7:4] == 4'b0111;
  endfunction

  always @(posedge clock_pulse) begin
    if (reset || clear) begin
      prog.delete();
      m_state = LOAD; m_pc = 0; m_valid = 0; m_ovf = 0; m_pc_known = 1;
    end else begin
      m_ovf = 0;
      if (m_state != RUN && start) begin
        if (prog.size() == 0 || is_halt(prog[0])) begin
          m_state = HALT; m_valid = 0; m_pc_known = 0;
        end else begin
          m_state = RUN; m_valid = 1; m_pc = 0; m_pc_known = 1;
        end
      end else if (m_state == LOAD && wr_en) begin
        if (prog.size() < 16) prog.push_back(wr_data);
        else m_ovf = 1;
      end else if (m_state == RUN && instr_ready) begin
        if (m_pc + 1 == prog.size()) begin
          if (loop_en) m_pc = 0;
          else begin m_state = HALT; m_valid = 0; end
        end else if (is_halt(prog[m_pc + 1])) begin
          m_state = HALT; m_valid = 0; m_pc = m_pc + 1;
        end else begin
          m_pc = m_pc + 1;
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare + transfer log ----------------
  logic [7:0] xfer[$];

  always @(negedge clock_pulse) begin
    if (cmp_en) begin
      chk("state", int'(state), m_state);
      chk("instr_valid", int'(instr_valid), int'(m_valid));
      chk("prog_len", int'(prog_len), prog.size());
      chk("wr_overflow", int'(wr_overflow), int'(m_ovf));
      if (m_pc_known) chk("pc", int'(pc), m_pc);
      if (m_valid) chk("instr_out", int'(instr_out), int'(prog[m_pc]));
      if (wr_overflow === 1'b1) ovf_pulses++;
      if (!reset && !clear && instr_valid === 1'b1 && instr_ready) xfer.push_back(instr_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock_pulse);
    #1;
  endtask

  task automatic write_word(logic [7:0] w);
    wr_en = 1'b1; wr_data = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_halt(string name, int budget);
    int n = 0;
    while (state !== 2'b10 && n < budget) begin tick(); n++; end
    chk({name, "_reached_halt"}, int'(state), 2);
  endtask

  task automatic chk_log(string name, input logic [7:0] e[$]);
    chk({name, "_count"}, xfer.size(), e.size());
    for (int i = 0; i < e.size() && i < xfer.size(); i++)
      chk($sformatf("%s_word%0d", name, i), int'(xfer[i]), int'(e[i]));
  endtask

  logic [7:0] exp_q[$];

  initial begin
    tick(); tick();
    cmp_en = 1'b1;
    reset = 1'b0;
    chk("reset_state", int'(state), 0);
    chk("reset_valid", int'(instr_valid), 0);
    chk("reset_prog_len", int'(prog_len), 0);
    chk("reset_pc", int'(pc), 0);
    chk("reset_instr_out", int'(instr_out), 0);

    // 1: straight-through issue with ready held high
    write_word(8'h14); write_word(8'h30); write_word(8'h04);
    chk("t1_prog_len", int'(prog_len), 3);
    instr_ready = 1'b1; xfer.delete();
    pulse_start();
    chk("t1_latency_valid", int'(instr_valid), 1);
    chk("t1_first_word", int'(instr_out), 8'h14);
    wait_halt("t1", 10);
    exp_q = '{8'h14, 8'h30, 8'h04};
    chk_log("t1", exp_q);
    chk("t1_final_pc", int'(pc), 2);
    chk("t1_valid_low", int'(instr_valid), 0);

    // 2: re-run from HALT, stall three cycles on the second word
    xfer.delete();
    pulse_start();
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_word", int'(instr_out), 8'h30);
      chk("t2_stall_pc", int'(pc), 1);
    end
    instr_ready = 1'b1;
    wait_halt("t2", 10);
    exp_q = '{8'h14, 8'h30, 8'h04};
    chk_log("t2", exp_q);

    // 3: HALT word embedded at index 1
    do_clear();
    write_word(8'h14); write_word(8'h70); write_word(8'h04);
    xfer.delete();
    pulse_start();
    wait_halt("t3", 10);
    exp_q = '{8'h14};
    chk_log("t3", exp_q);
    chk("t3_final_pc", int'(pc), 1);

    // 4: overflow on the 17th write
    do_clear();
    ovf_pulses = 0;
    for (int i = 0; i < 16; i++) write_word(8'h20 + 8'(i));
    write_word(8'h99);
    chk("t4_ovf_pulse", int'(wr_overflow), 1);
    tick();
    chk("t4_ovf_cleared", int'(wr_overflow), 0);
    chk("t4_ovf_count", ovf_pulses, 1);
    chk("t4_prog_len", int'(prog_len), 16);
    xfer.delete();
    pulse_start();
    wait_halt("t4", 40);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h20 + 8'(i));
    chk_log("t4", exp_q);
    chk("t4_final_pc", int'(pc), 15);

    // 5: loop mode, then drop loop_en before the next wrap
    do_clear();
    write_word(8'h31); write_word(8'h12);
    loop_en = 1'b1; xfer.delete();
    pulse_start();
    for (int n = 0; n < 20 && xfer.size() < 5; n++) tick();
    loop_en = 1'b0;
    wait_halt("t5", 10);
    exp_q = '{8'h31, 8'h12, 8'h31, 8'h12, 8'h31, 8'h12};
    chk_log("t5", exp_q);
    chk("t5_final_pc", int'(pc), 1);

    // 6a: reset mid-run, then start with nothing loaded
    loop_en = 1'b1;
    pulse_start();
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_reset_state", int'(state), 0);
    chk("t6_reset_valid", int'(instr_valid), 0);
    chk("t6_reset_len", int'(prog_len), 0);
    xfer.delete();
    pulse_start();
    chk("t6_empty_halt", int'(state), 2);
    tick(); tick();
    chk("t6_nothing_issued", xfer.size(), 0);

    // 6b: start+wr_en together, single-word loop, then clear mid-run
    do_clear();
    write_word(8'h31);
    wr_en = 1'b1; wr_data = 8'h55;
    pulse_start();
    wr_en = 1'b0;
    chk("t6_start_beats_write_len", int'(prog_len), 1);
    chk("t6_start_beats_write_ovf", int'(wr_overflow), 0);
    xfer.delete();
    tick(); tick(); tick();
    exp_q = '{8'h31, 8'h31, 8'h31};
    chk_log("t6_single_loop", exp_q);
    do_clear();
    chk("t6_clear_state", int'(state), 0);
    chk("t6_clear_valid", int'(instr_valid), 0);
    chk("t6_clear_len", int'(prog_len), 0);
    xfer.delete();
    pulse_start();
    chk("t6_clear_empty_halt", int'(state), 2);
    tick();
    chk("t6_clear_nothing_issued", xfer.size(), 0);

    instr_ready = 1'b0; loop_en = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
